// File: rtl/mux16_scan_ctrl.sv
// Scan controller for a 16:1 mux: steps the select lines, samples the mux output
// after a settle delay, and presents the assembled word over valid/ready.
module mux16_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        single,
  input  logic [3:0]  chan,
  output logic [3:0]  sel,
  input  logic        mux_out,
  output logic [15:0] data,
  output logic        valid,
  input  logic        ready,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CH_W   = 4;
  localparam int unsigned DATA_W = 16;

  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE);
  localparam bit               HAS_SETTLE = (SETTLE != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                single_q, single_d;
  logic                overrun_q, overrun_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    single_d  = single_q;
    overrun_d = overrun_q;

    if (start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d    = '0;
          overrun_d = 1'b0;
          sel_d     = single ? chan : '0;
          single_d  = single;
          cnt_d     = SETTLE_LD;
          state_d   = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        data_d[sel_q] = mux_out;
        if (single_q || (sel_q == {CH_W{1'b1}})) begin
          state_d = ST_HOLD;
        end else begin
          sel_d   = sel_q + CH_W'(1);
          cnt_d   = SETTLE_LD;
          state_d = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
        end
      end
      ST_HOLD: begin
        if (ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_HOLD);
    busy_d  = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      single_q  <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      single_q  <= single_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign sel     = sel_q;
  assign data    = data_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Bench for mux16_scan_ctrl: two instances (SETTLE=1 and SETTLE=0) driven by
// directed and random scans, checked against a scan-level reference model.
module tb_mux16_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_s   [2];
  logic        single_s  [2];
  logic [3:0]  chan_s    [2];
  logic [3:0]  sel_s     [2];
  logic        mux_out_s [2];
  logic [15:0] data_s    [2];
  logic        valid_s   [2];
  logic        ready_s   [2];
  logic        busy_s    [2];
  logic        overrun_s [2];
  logic [15:0] pat       [2];

  int n_checks;
  int n_fail;

  mux16_scan_ctrl #(.SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .single(single_s[0]),
    .chan(chan_s[0]), .sel(sel_s[0]), .mux_out(mux_out_s[0]), .data(data_s[0]),
    .valid(valid_s[0]), .ready(ready_s[0]), .busy(busy_s[0]), .overrun(overrun_s[0])
  );

  mux16_scan_ctrl #(.SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .single(single_s[1]),
    .chan(chan_s[1]), .sel(sel_s[1]), .mux_out(mux_out_s[1]), .data(data_s[1]),
    .valid(valid_s[1]), .ready(ready_s[1]), .busy(busy_s[1]), .overrun(overrun_s[1])
  );

  // Behavioural 16:1 muxes in front of each instance
  assign mux_out_s[0] = pat[0][sel_s[0]];
  assign mux_out_s[1] = pat[1][sel_s[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // One complete scan starting at a negedge: start, sweep, optional stray start,
  // backpressure, handshake. Returns positioned at the negedge after the handshake.
  task automatic run_scan(input int d, input bit sgl, input logic [3:0] ch,
                          input logic [15:0] p, input int rdy_wait, input int ov_in);
    int s;
    int lat;
    int k;
    int busy_cnt;
    int ov_at;
    bit ov_exp;
    logic [15:0] exp_data;
    logic [15:0] one_bit;

    s   = settle_of(d);
    lat = sgl ? (s + 1) : 16 * (s + 1);
    ov_at = (ov_in >= lat) ? lat - 1 : ov_in;
    one_bit = 16'(p[ch]);
    exp_data = sgl ? (one_bit << ch) : p;

    pat[d]      = p;
    start_s[d]  = 1'b1;
    single_s[d] = sgl;
    chan_s[d]   = ch;
    @(negedge clk);
    start_s[d]  = 1'b0;
    single_s[d] = 1'($urandom);
    chan_s[d]   = 4'($urandom);
    check("ovr_clr_on_start", 32'(overrun_s[d]), 32'd0);

    k = 0;
    busy_cnt = 0;
    ov_exp = 1'b0;
    while ((k <= lat + 2) && !valid_s[d]) begin
      if (busy_s[d]) busy_cnt++;
      if (k < lat) check("sel_step", 32'(sel_s[d]), sgl ? 32'(ch) : 32'(k / (s + 1)));
      if (k == ov_at) begin
        start_s[d] = 1'b1;
        ov_exp = 1'b1;
      end else begin
        start_s[d] = 1'b0;
      end
      ready_s[d] = 1'($urandom);
      @(negedge clk);
      k++;
    end
    start_s[d] = 1'b0;
    ready_s[d] = 1'b0;

    check("valid_latency", 32'(k), 32'(lat));
    check("busy_cycles", 32'(busy_cnt), 32'(lat));
    check("data", 32'(data_s[d]), 32'(exp_data));
    check("sel_hold", 32'(sel_s[d]), sgl ? 32'(ch) : 32'd15);
    check("busy_hold", 32'(busy_s[d]), 32'd0);
    check("overrun", 32'(overrun_s[d]), 32'(ov_exp));

    for (int i = 0; i < rdy_wait; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(valid_s[d]), 32'd1);
      check("bp_data", 32'(data_s[d]), 32'(exp_data));
      check("bp_overrun", 32'(overrun_s[d]), 32'(ov_exp));
    end

    ready_s[d] = 1'b1;
    @(negedge clk);
    ready_s[d] = 1'b0;
    check("valid_drop", 32'(valid_s[d]), 32'd0);
    check("busy_idle", 32'(busy_s[d]), 32'd0);
    check("overrun_idle", 32'(overrun_s[d]), 32'(ov_exp));
  endtask

  // Reset asserted mid-sweep on the SETTLE=1 instance while sel is 7
  task automatic reset_mid_sweep();
    pat[0]      = 16'hFFFF;
    start_s[0]  = 1'b1;
    single_s[0] = 1'b0;
    chan_s[0]   = 4'd0;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int k = 0; k < 14; k++) @(negedge clk);
    check("pre_rst_sel", 32'(sel_s[0]), 32'd7);
    check("pre_rst_data", 32'(data_s[0]), 32'h007F);
    rst_n = 1'b0;
    #1;
    check("rst_sel", 32'(sel_s[0]), 32'd0);
    check("rst_data", 32'(data_s[0]), 32'd0);
    check("rst_valid", 32'(valid_s[0]), 32'd0);
    check("rst_busy", 32'(busy_s[0]), 32'd0);
    check("rst_overrun", 32'(overrun_s[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d]  = 1'b0;
      single_s[d] = 1'b0;
      chan_s[d]   = 4'd0;
      ready_s[d]  = 1'b0;
      pat[d]      = 16'h0000;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("init_sel", 32'(sel_s[d]), 32'd0);
      check("init_data", 32'(data_s[d]), 32'd0);
      check("init_valid", 32'(valid_s[d]), 32'd0);
      check("init_busy", 32'(busy_s[d]), 32'd0);
      check("init_overrun", 32'(overrun_s[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    reset_mid_sweep();
    run_scan(0, 1'b0, 4'd0, 16'hA5C3, 0, -1);
    run_scan(1, 1'b1, 4'd9, 16'hFFFF, 0, -1);
    run_scan(0, 1'b0, 4'd0, 16'h3C96, 10, -1);
    run_scan(0, 1'b0, 4'd0, 16'h5A5A, 3, 5);
    run_scan(0, 1'b1, 4'd3, 16'h0008, 0, -1);
    run_scan(1, 1'b0, 4'd0, 16'hFFFF, 0, -1);
    run_scan(1, 1'b1, 4'd15, 16'h8000, 2, 0);

    for (int n = 0; n < 24; n++) begin
      int d;
      int ov;
      d  = int'($urandom_range(0, 1));
      ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
      run_scan(d, 1'($urandom), 4'($urandom), 16'($urandom), int'($urandom_range(0, 4)), ov);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux16_scan_ctrl.md
# mux16_scan_ctrl

Sequential scan controller that drives the select lines of the 16:1 multiplexer and captures its single-bit output, either sweeping all 16 channels or sampling a single channel. Captured bits are assembled into a 16-bit word. The word is presented downstream through a valid/ready handshake. The block sits directly around the mux: `sel` feeds the mux select input, and `mux_out` is the mux output.

## Interface
Parameters:
- `SETTLE`, default 1: wait cycles between a `sel` change and the sample. Legal range is 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. Asserting it forces the reset state immediately; release is synchronous to `clk`.
- `start`  in  1  request a scan. Sampled only in IDLE.
- `single`  in  1  at accepted start: 1 = sample `chan` only; 0 = full sweep of channels 0..15.
- `chan`  in  4  channel for single mode. Sampled at accepted start.
- `sel`  out  4  mux select.
- `mux_out`  in  1  mux output bit.
- `data`  out  16  captured word. Bit i holds the sample taken with `sel`=i.
- `valid`  out  1  `data` is complete and held.
- `ready`  in  1  downstream accepts `data`.
- `busy`  out  1  scan in progress (SETTLE or SAMPLE state).
- `overrun`  out  1  sticky flag: `start` was asserted while not in IDLE.

## Operation
- Reset values: `sel`=0, `data`=0, `valid`=0, `busy`=0, `overrun`=0, state IDLE, settle counter 0.
- FSM states: IDLE, SETTLE, SAMPLE, HOLD.
- **IDLE.** On `start`=1:
  - Clear `data` to 0 and clear `overrun`.
  - Load `sel` with `chan` if `single`=1, else with 0. Latch the mode.
  - Load the settle counter with `SETTLE`.
  - Go to SETTLE if `SETTLE`>0, else to SAMPLE.
- **SETTLE.** Decrement the counter each cycle. When the counter reaches 1, the next state is SAMPLE. The state lasts exactly `SETTLE` cycles.
- **SAMPLE.** Lasts one cycle. `data[sel]` <= `mux_out`. Then:
  - Single mode: go to HOLD.
  - Full mode with `sel`=15: go to HOLD. `sel` stays at 15 and does not wrap.
  - Full mode otherwise: `sel` <= `sel`+1, reload the counter, and go to SETTLE, or stay in SAMPLE if `SETTLE`=0.
- **HOLD.** `valid`=1. `data` and `sel` are held.
  - When `valid` and `ready` are both 1 on an edge, go to IDLE and drop `valid` on the next cycle.
  - `ready` is ignored outside HOLD.
- **`start` outside IDLE.** It is ignored, and `overrun` is set to 1. This applies in SETTLE, SAMPLE and HOLD, including the cycle in which the handshake completes. `overrun` is cleared only by the next accepted start or by reset.
- **Start in the cycle after the handshake.** `start` is accepted in the first IDLE cycle, so back-to-back scans need no gap cycle beyond that IDLE cycle.
- **Single-mode data.** `data` holds at most one set bit, at position `chan`.
- `busy` is 1 in SETTLE and SAMPLE, and 0 in IDLE and HOLD.
- **Reset mid-scan.** All outputs return to reset values and any partial `data` is discarded.

## Timing
- Start accepted at edge 0.
- Per channel: `SETTLE`+1 cycles. `sel` is stable for that whole window before the sample edge.
- Full sweep: `valid` rises 16×(`SETTLE`+1) cycles after edge 0. With `SETTLE`=1, that is cycle 32.
- Single: `valid` rises `SETTLE`+1 cycles after edge 0.
- `sel` changes only at the SAMPLE→next edge or at start acceptance. It never changes during SETTLE.
- Minimum period from one accepted start to the next is scan length + 1 (handshake) + 1 (IDLE).

## Test plan
- **Reset values.** Assert `rst_n`=0 mid-sweep at `sel`=7 → outputs immediately return to `sel`=0, `data`=0, `valid`=0, `busy`=0. A new start afterwards produces a clean sweep.
- **Full sweep, `SETTLE`=1.** Drive `mux_out` from a model mux with inputs 16'hA5C3 and `ready`=1. Expect `valid` at cycle 32 with `data`=16'hA5C3. `sel` must step 0..15, each value held 2 cycles.
- **Single mode.** `chan`=9, `mux_out`=1, `SETTLE`=0 → `valid` one cycle after start with `data`=16'h0200 and `sel`=9.
- **Backpressure.** Hold `ready`=0 for 10 cycles after `valid` → `valid` and `data` are held. Raise `ready` → `valid` drops the next cycle. A start in the first IDLE cycle is accepted.
- **Overrun.** Pulse `start` at cycle 5 of a sweep → scan completes unaffected and `overrun`=1. It stays 1 through HOLD and clears at the next accepted start.
- **`SETTLE`=0 sweep.** Inputs 16'hFFFF → `busy` is high for exactly 16 cycles and `data`=16'hFFFF.
